key_space_dispatcher: RTL and testbench

Parametrised successor to the single-channel secret-key counter in the RC4 cracker. Sweeps a programmable key range `[key_lo, key_hi]` and hands one key per grant to `NUM_CH` parallel decrypt/check channels using round-robin arbitration. Tracks which channels hold a key, stops issuing keys on the first reported match, drains the outstanding channels, then reports `done` together with the winning key or exhaustion.

---
 rtl/key_space_dispatcher.sv | 182 ++++++++++++++++++
 tb/tb_key_space_dispatcher.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_space_dispatcher.sv
// key_space_dispatcher: sweeps [key_lo, key_hi] and hands one key per cycle
// to NUM_CH decrypt/check channels in round-robin order. Stops on the first
// reported match, drains the channels still holding keys, then raises done
// with the winning key or with found = 0 when the range is exhausted.
`timescale 1ns/1ps
module key_space_dispatcher #(
  parameter int KEY_W  = 24,
  parameter int NUM_CH = 4,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [KEY_W-1:0]        key_lo,
  input  logic [KEY_W-1:0]        key_hi,
  input  logic [NUM_CH-1:0]       ch_ready,
  input  logic [NUM_CH-1:0]       ch_done,
  input  logic [NUM_CH-1:0]       ch_found,
  output logic [NUM_CH-1:0]       ch_gnt,
  output logic [NUM_CH*KEY_W-1:0] ch_key,
  output logic                    busy,
  output logic                    done,
  output logic                    found,
  output logic [KEY_W-1:0]        found_key,
  output logic [CH_W-1:0]         found_ch,
  output logic [KEY_W:0]          keys_issued,
  output logic [1:0]              state_dbg
);

  // Channel handshake: a channel is eligible when ch_ready[i] is high and it
  // holds no key. A grant is a one-cycle ch_gnt[i] pulse with ch_key slice i
  // valid in the same cycle; the channel then owns that key until it pulses
  // ch_done[i] (ch_found[i] qualified by ch_done[i]). Done pulses from a
  // channel that holds no key carry no meaning and are dropped.

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  localparam logic [KEY_W:0] ONE = 1;

  state_t              state;
  logic [KEY_W:0]      next_key;
  logic [KEY_W-1:0]    key_hi_q;
  logic [NUM_CH-1:0]   outstanding;
  logic [CH_W-1:0]     rr_ptr;

  logic [NUM_CH-1:0]   eligible;
  logic [NUM_CH-1:0]   match_vec;
  logic [NUM_CH-1:0]   gnt_vec;
  logic                gnt_hit;
  logic [CH_W-1:0]     gnt_idx;
  logic [CH_W-1:0]     gnt_next_ptr;
  logic                match_hit;
  logic [CH_W-1:0]     match_idx;
  logic [KEY_W-1:0]    match_key;

  assign state_dbg = state;
  assign eligible  = ch_ready & ~outstanding;
  assign match_vec = ch_done & ch_found & outstanding;

  function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_CH) s = s - NUM_CH;
    return CH_W'(s);
  endfunction

  // Round-robin search from rr_ptr; descending scan so the nearest hit wins.
  always_comb begin
    gnt_hit = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (eligible[wrap_add(rr_ptr, k)]) begin
        gnt_hit = 1'b1;
        gnt_idx = wrap_add(rr_ptr, k);
      end
    end
  end

  // Lowest-index match wins when several channels report in the same cycle.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    match_key = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (match_vec[k]) begin
        match_hit = 1'b1;
        match_idx = CH_W'(k);
        match_key = ch_key[k*KEY_W +: KEY_W];
      end
    end
  end

  // A match in the same cycle suppresses the grant, so no key leaves after it.
  always_comb begin
    gnt_vec = '0;
    if (state == RUN && gnt_hit && !match_hit) gnt_vec[gnt_idx] = 1'b1;
    gnt_next_ptr = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
  end

  // Sweep FSM with all outputs registered; abort outranks every state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ch_gnt      <= '0;
      ch_key      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      found_key   <= '0;
      found_ch    <= '0;
      keys_issued <= '0;
      rr_ptr      <= '0;
      outstanding <= '0;
      next_key    <= '0;
      key_hi_q    <= '0;
    end else if (abort) begin
      state       <= IDLE;
      ch_gnt      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      rr_ptr      <= '0;
      outstanding <= '0;
    end else begin
      ch_gnt <= gnt_vec;
      for (int i = 0; i < NUM_CH; i++) begin
        if (gnt_vec[i]) ch_key[i*KEY_W +: KEY_W] <= next_key[KEY_W-1:0];
      end
      case (state)
        IDLE, DONE: begin
          if (start) begin
            key_hi_q    <= key_hi;
            next_key    <= {1'b0, key_lo};
            outstanding <= '0;
            keys_issued <= '0;
            found       <= 1'b0;
            if (key_lo > key_hi) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end
        RUN: begin
          outstanding <= (outstanding & ~ch_done) | gnt_vec;
          if (match_hit) begin
            found     <= 1'b1;
            found_key <= match_key;
            found_ch  <= match_idx;
            state     <= DRAIN;
          end else if (gnt_hit) begin
            next_key    <= next_key + ONE;
            keys_issued <= keys_issued + ONE;
            rr_ptr      <= gnt_next_ptr;
            // next_key is one bit wider than key_hi so the all-ones key ends cleanly.
            if (next_key >= {1'b0, key_hi_q}) state <= DRAIN;
          end
        end
        DRAIN: begin
          outstanding <= outstanding & ~ch_done;
          if (match_hit && !found) begin
            found     <= 1'b1;
            found_key <= match_key;
            found_ch  <= match_idx;
          end
          if (outstanding == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_space_dispatcher.sv
// Directed bench for key_space_dispatcher: a channel responder answers each
// grant after a per-channel delay, and every grant is matched against an
// expected (channel, key) queue built from hand-computed sequences.
`timescale 1ns/1ps
module tb_key_space_dispatcher;
  localparam int KEY_W  = 24;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int EW     = 4 + KEY_W;

  logic                    clk;
  logic                    reset;
  logic                    start;
  logic                    abort;
  logic [KEY_W-1:0]        key_lo;
  logic [KEY_W-1:0]        key_hi;
  logic [NUM_CH-1:0]       ch_ready;
  logic [NUM_CH-1:0]       ch_done;
  logic [NUM_CH-1:0]       ch_found;
  logic [NUM_CH-1:0]       ch_gnt;
  logic [NUM_CH*KEY_W-1:0] ch_key;
  logic                    busy;
  logic                    done;
  logic                    found;
  logic [KEY_W-1:0]        found_key;
  logic [CH_W-1:0]         found_ch;
  logic [KEY_W:0]          keys_issued;
  logic [1:0]              state_dbg;

  int total;
  int bad;
  logic [EW-1:0] exp_q[$];
  int cnt[NUM_CH];
  int dly[NUM_CH];
  logic [NUM_CH-1:0] fmask;

  key_space_dispatcher #(.KEY_W(KEY_W), .NUM_CH(NUM_CH)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .key_lo(key_lo), .key_hi(key_hi),
    .ch_ready(ch_ready), .ch_done(ch_done), .ch_found(ch_found),
    .ch_gnt(ch_gnt), .ch_key(ch_key),
    .busy(busy), .done(done), .found(found),
    .found_key(found_key), .found_ch(found_ch),
    .keys_issued(keys_issued), .state_dbg(state_dbg)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog sim_time_expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [KEY_W-1:0] key_of(input int i);
    return ch_key[i*KEY_W +: KEY_W];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: sample after the edge, score grants, then drive responder.
  task automatic tick();
    int g;
    logic [EW-1:0] obs;
    logic [EW-1:0] expv;
    @(posedge clk);
    #1;
    if (ch_gnt != '0) begin
      g = 0;
      for (int i = NUM_CH - 1; i >= 0; i--) if (ch_gnt[i]) g = i;
      obs = {4'(g), key_of(g)};
      if ($countones(ch_gnt) != 1) obs = '1;
      if (exp_q.size() > 0) expv = exp_q.pop_front();
      else expv = 'x;
      total++;
      assert (obs === expv) else begin
        bad++;
        $error("FAIL grant observed=%0h expected=%0h", obs, expv);
      end
    end
    ch_done  = '0;
    ch_found = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) begin
          ch_done[i]  = 1'b1;
          ch_found[i] = fmask[i];
        end
      end
    end
    for (int i = 0; i < NUM_CH; i++) if (ch_gnt[i]) cnt[i] = dly[i];
  endtask

  task automatic start_sweep(input logic [KEY_W-1:0] lo, input logic [KEY_W-1:0] hi);
    key_lo = lo;
    key_hi = hi;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Bounded wait for done; n counts edges since start was sampled-driven.
  task automatic run_to_done(input string tag, input int exp_n, input int n0);
    int n;
    n = n0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_done_cycle"}, n, exp_n);
  endtask

  task automatic push_exp(input int ch, input logic [KEY_W-1:0] key);
    exp_q.push_back({4'(ch), key});
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    key_lo = '0; key_hi = '0;
    ch_ready = '1; ch_done = '0; ch_found = '0; fmask = '0;
    for (int i = 0; i < NUM_CH; i++) begin cnt[i] = 0; dly[i] = 3; end

    // reset state
    tick(); tick();
    check("rst_state", state_dbg, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_found", found, 0);
    check("rst_gnt", ch_gnt, 0);
    check("rst_key", {31'b0, |ch_key}, 0);
    check("rst_issued", keys_issued, 0);
    reset = 1'b0;
    tick();
    check("idle_hold", state_dbg, 0);

    // plain sweep 0x10..0x17, no match
    for (int i = 0; i < 8; i++) push_exp(i % 4, KEY_W'(32'h10 + i));
    start_sweep(24'h10, 24'h17);
    check("s1_busy", busy, 1);
    check("s1_state_run", state_dbg, 1);
    check("s1_no_gnt_e1", ch_gnt, 0);
    tick();
    check("s1_gnt_e2", ch_gnt, 4'b0001);
    check("s1_key_e2", key_of(0), 24'h10);
    run_to_done("s1", 15, 2);
    check("s1_found", found, 0);
    check("s1_issued", keys_issued, 8);
    check("s1_busy_off", busy, 0);
    check("s1_q_empty", exp_q.size(), 0);

    // channel 2 matches key 0x12
    fmask = 4'b0100;
    push_exp(0, 24'h10); push_exp(1, 24'h11); push_exp(2, 24'h12);
    push_exp(3, 24'h13); push_exp(0, 24'h14);
    start_sweep(24'h10, 24'h17);
    run_to_done("s2", 12, 1);
    check("s2_found", found, 1);
    check("s2_found_key", found_key, 24'h12);
    check("s2_found_ch", found_ch, 2);
    check("s2_issued", keys_issued, 5);
    check("s2_q_empty", exp_q.size(), 0);

    // channels 1 and 3 match in the same cycle
    fmask = 4'b1010;
    dly[0] = 3; dly[1] = 4; dly[2] = 3; dly[3] = 2;
    push_exp(1, 24'h30); push_exp(2, 24'h31); push_exp(3, 24'h32); push_exp(0, 24'h33);
    start_sweep(24'h30, 24'h3F);
    run_to_done("s3", 10, 1);
    check("s3_found", found, 1);
    check("s3_found_ch", found_ch, 1);
    check("s3_found_key", found_key, 24'h30);
    check("s3_issued", keys_issued, 4);
    check("s3_q_empty", exp_q.size(), 0);
    fmask = '0;
    for (int i = 0; i < NUM_CH; i++) dly[i] = 3;

    // single all-ones key, no wrap
    push_exp(1, 24'hFFFFFF);
    start_sweep(24'hFFFFFF, 24'hFFFFFF);
    run_to_done("s4", 7, 1);
    check("s4_issued", keys_issued, 1);
    check("s4_found", found, 0);
    check("s4_key", key_of(1), 24'hFFFFFF);
    check("s4_q_empty", exp_q.size(), 0);

    // empty range
    start_sweep(24'd5, 24'd4);
    check("s5_done", done, 1);
    check("s5_state", state_dbg, 3);
    check("s5_busy", busy, 0);
    check("s5_issued", keys_issued, 0);
    check("s5_found", found, 0);
    tick(); tick(); tick();
    check("s5_done_hold", done, 1);

    // abort with two keys outstanding, then a fresh sweep from channel 0
    push_exp(2, 24'h40); push_exp(3, 24'h41);
    start_sweep(24'h40, 24'h4F);
    tick(); tick();
    check("s6_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("s6_abort_state", state_dbg, 0);
    check("s6_abort_busy", busy, 0);
    check("s6_abort_gnt", ch_gnt, 0);
    check("s6_key2_kept", key_of(2), 24'h40);
    check("s6_key3_kept", key_of(3), 24'h41);
    repeat (5) tick();
    check("s6_idle_hold", state_dbg, 0);
    push_exp(0, 24'h20); push_exp(1, 24'h21);
    start_sweep(24'h20, 24'h21);
    run_to_done("s6b", 8, 1);
    check("s6b_issued", keys_issued, 2);
    check("s6b_found", found, 0);
    check("s6b_q_empty", exp_q.size(), 0);

    // asynchronous reset in DRAIN
    push_exp(2, 24'h50); push_exp(3, 24'h51);
    start_sweep(24'h50, 24'h51);
    tick(); tick();
    check("s7_drain", state_dbg, 2);
    #2;
    reset = 1'b1;
    #1;
    check("s7_rst_state", state_dbg, 0);
    check("s7_rst_busy", busy, 0);
    check("s7_rst_gnt", ch_gnt, 0);
    check("s7_rst_key", {31'b0, |ch_key}, 0);
    check("s7_rst_issued", keys_issued, 0);
    check("s7_rst_found_key", found_key, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("s7_no_gnt", ch_gnt, 0);
    end
    check("s7_idle", state_dbg, 0);
    check("s7_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
